mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access unit, directly upstream of the MEM/WB pipeline register. It takes the EX/MEM-registered memory operation, drives a ready-handshaked data-memory port, and builds store byte-enables and lane-replicated write data. It stalls the front of the pipeline until the access completes. It gates the register write enable so that MEM/WB captures a bubble while stalled, then presents the raw read word as ME_Dout.

## Interface
Parameters:
- TIMEOUT, 15: maximum wait cycles for dmem_ready; used only with DMEM_TIMEOUT_EN.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- ME_MemRead  in  1  load in MEM stage
- ME_MemWrite  in  1  store in MEM stage
- ME_ALUResult  in  32  byte address
- ME_StoreData  in  32  store source register value
- ME_store_option  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ME_WriteEnable_in  in  1  register write enable from EX/MEM
- ME_WriteEnable  out  1  gated write enable to MEM/WB
- ME_Dout  out  32  raw aligned read word to MEM/WB
- ME_Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- dmem_req  out  1  access request
- dmem_we  out  1  1 store, 0 load
- dmem_addr  out  32  {ME_ALUResult[31:2], 2'b00}
- dmem_be  out  4  byte enables (stores only; 4'b0000 on loads)
- dmem_wdata  out  32  replicated store data
- dmem_ready  in  1  memory completes transfer this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready
- ME_BusErr  out  1  sticky timeout flag (DMEM_TIMEOUT_EN only; otherwise tied 0)

## Operation
- memop = ME_MemRead | ME_MemWrite. If both are set, the access is a store.
- FSM states IDLE, WAIT, DONE. Reset value: IDLE.
- IDLE: if memop, drive dmem_req=1. On dmem_ready go to DONE and latch the read data; otherwise go to WAIT. If there is no memop, stay in IDLE.
- WAIT: hold dmem_req and all dmem_* outputs stable. On dmem_ready go to DONE and latch the read data.
- DONE: dmem_req=0. Unconditionally return to IDLE; the pipeline advances at this edge.
- ME_Stall = memop & (state != DONE).
- ME_WriteEnable = ME_WriteEnable_in & ~ME_Stall.
- Transfer occurs on the cycle where dmem_req & dmem_ready. On a load transfer, rdata_q <= dmem_rdata.
- ME_Dout:
  - rdata_q in DONE for a load.
  - 0 for stores.
  - 0 for non-memory instructions.
  - 0 while stalled.
- Store byte enables and data:
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}. addr[0] is ignored.
  - Word: be = 4'b1111; wdata = data. addr[1:0] is ignored.
- dmem_ready is ignored while dmem_req=0.

## Timing
- Zero-wait memory (ready in IDLE): a memop spends 2 cycles in MEM, with 1 stall cycle.
- N wait cycles: the memop spends N+2 cycles in MEM.
- Non-memory instruction: 1 cycle, no stall.
- Back-to-back memops: DONE→IDLE, then a new request on the next cycle. No request is issued in DONE.
- Reset low: all outputs forced to 0 combinationally (dmem_req, ME_Stall, ME_WriteEnable, ME_Dout, ME_BusErr). At the edge: state ← IDLE, rdata_q ← 0, counter ← 0, ME_BusErr ← 0.
- Reset mid-WAIT: the request drops in the same cycle. A late dmem_ready is ignored.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - A wait counter (width clog2(TIMEOUT+1)) increments each WAIT cycle and clears on leaving WAIT.
  - When the counter reaches TIMEOUT without ready, the access is aborted: go to DONE, rdata_q ← 32'hDEADBEEF, ME_BusErr ← 1 (sticky until reset).
  - Ready on the same cycle as the timeout wins; no error is raised.
- DMEM_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely; ME_BusErr tied 0.

## Structure
- Shared package holds:
  - state encoding (IDLE/WAIT/DONE);
  - store_option encodings;
  - TIMEOUT default;
  - the 32'hDEADBEEF error word.
- Sub-module mem_store_align: combinational (store_option, addr[1:0], data) → (be, wdata).

## Test plan
- Load, addr 0x104, ready in IDLE, rdata 0x11223344 → stall for 1 cycle, dmem_addr 0x104, ME_Dout=0x11223344 in DONE, ME_WriteEnable=1 in DONE only.
- Store byte, addr 0x203, data 0xAABBCCDD, 3 wait cycles → dmem_be 4'b1000, wdata 0xDDDDDDDD, dmem_we=1, stall for 4 cycles, req stable throughout, ME_Dout=0.
- Store half, addr 0x202, data 0x1234 → be 4'b1100, wdata 0x12341234. Store word at addr 0x207 → dmem_addr 0x204, be 4'b1111.
- Two consecutive loads, zero-wait → dmem_req pattern 1,0,1,0. Each load delivers its own rdata.
- Reset asserted in WAIT → dmem_req and ME_Stall drop the same cycle. After release, state is IDLE and ME_Dout=0.
- With DMEM_TIMEOUT_EN and TIMEOUT=4, ready never asserted → abort after 4 WAIT cycles, ME_Dout=0xDEADBEEF, ME_BusErr=1 and sticky.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// FSM state encoding, store-size encodings, timeout default and bus-error word.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SO_BYTE     = 2'b00,
    SO_HALF     = 2'b01,
    SO_WORD     = 2'b10,
    SO_WORD_ALT = 2'b11
  } store_opt_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam logic [31:0] BUS_ERR_WORD    = 32'hDEADBEEF;

endpackage

// File: rtl/mem_store_align.sv
// Store lane steering: byte enables and lane-replicated write data
// from store size, the low address bits and the raw store operand.
module mem_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  store_option_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = data_i;
    case (store_opt_e'(store_option_i))
      SO_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{data_i[7:0]}};
      end
      SO_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: ready-handshaked memory port, pipeline
// stall and write-enable gating. Optional wait timeout under DMEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ME_MemRead,
  input  logic        ME_MemWrite,
  input  logic [31:0] ME_ALUResult,
  input  logic [31:0] ME_StoreData,
  input  logic [1:0]  ME_store_option,
  input  logic        ME_WriteEnable_in,
  output logic        ME_WriteEnable,
  output logic [31:0] ME_Dout,
  output logic        ME_Stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        ME_BusErr
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req;
  logic        memop;
  logic        is_load;
  logic [3:0]  be;
  logic [31:0] wdata;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buserr_q, buserr_d;
`endif

  assign memop   = ME_MemRead | ME_MemWrite;
  assign is_load = ME_MemRead & ~ME_MemWrite;

  mem_store_align u_align (
    .store_option_i (ME_store_option),
    .addr_lo_i      (ME_ALUResult[1:0]),
    .data_i         (ME_StoreData),
    .be_o           (be),
    .wdata_o        (wdata)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    req     = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d    = '0;
    buserr_d = buserr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (memop) begin
          req = 1'b1;
          if (dmem_ready) begin
            state_d = ST_DONE;
            if (is_load) rdata_d = dmem_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem_ready) begin
          state_d = ST_DONE;
          if (is_load) rdata_d = dmem_rdata;
        end else begin
`ifdef DMEM_TIMEOUT_EN
          // Abort on the TIMEOUT-th WAIT cycle; a same-cycle ready takes the branch above.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_d  = ST_DONE;
            rdata_d  = BUS_ERR_WORD;
            buserr_d = 1'b1;
            cnt_d    = '0;
          end
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= '0;
      buserr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
`endif
    end
  end

  // Reset forces the pipeline-facing outputs low in the same cycle.
  assign dmem_req       = reset & req;
  assign ME_Stall       = reset & memop & (state_q != ST_DONE);
  assign ME_WriteEnable = reset & ME_WriteEnable_in & ~ME_Stall;
  assign ME_Dout        = (reset && state_q == ST_DONE && is_load) ? rdata_q : '0;
  assign dmem_we        = dmem_req & ME_MemWrite;
  assign dmem_addr      = {ME_ALUResult[31:2], 2'b00};
  assign dmem_be        = ME_MemWrite ? be : '0;
  assign dmem_wdata     = wdata;

`ifdef DMEM_TIMEOUT_EN
  assign ME_BusErr = reset & buserr_q;
`else
  assign ME_BusErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a
// per-transaction timing/data model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ME_MemRead, ME_MemWrite;
  logic [31:0] ME_ALUResult, ME_StoreData;
  logic [1:0]  ME_store_option;
  logic        ME_WriteEnable_in;
  logic        ME_WriteEnable;
  logic [31:0] ME_Dout;
  logic        ME_Stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        ME_BusErr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        exp_buserr = 1'b0;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .ME_MemRead        (ME_MemRead),
    .ME_MemWrite       (ME_MemWrite),
    .ME_ALUResult      (ME_ALUResult),
    .ME_StoreData      (ME_StoreData),
    .ME_store_option   (ME_store_option),
    .ME_WriteEnable_in (ME_WriteEnable_in),
    .ME_WriteEnable    (ME_WriteEnable),
    .ME_Dout           (ME_Dout),
    .ME_Stall          (ME_Stall),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .ME_BusErr         (ME_BusErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic [1:0] opt, input logic [31:0] addr);
    int unsigned lane = addr % 4;
    if (opt == 2'd0) return 4'(1 << lane);
    if (opt == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] opt, input logic [31:0] data);
    if (opt == 2'd0) return (data % 256) * 32'h0101_0101;
    if (opt == 2'd1) return (data % 65536) * 32'h0001_0001;
    return data;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One instruction through MEM: nwait cycles without ready, then ready,
  // then one DONE cycle; a non-memory instruction takes a single cycle.
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] opt,
                        input bit wen, input int unsigned nwait, input logic [31:0] rword);
    bit memop = rd | wr;
    bit load  = rd & ~wr;
    ME_MemRead        = rd;
    ME_MemWrite       = wr;
    ME_ALUResult      = addr;
    ME_StoreData      = data;
    ME_store_option   = opt;
    ME_WriteEnable_in = wen;
    if (memop) begin
      for (int unsigned c = 0; c <= nwait; c++) begin
        dmem_ready = (c == nwait);
        dmem_rdata = (c == nwait) ? rword : $urandom;
        @(negedge clock);
        check("req_busy",   dmem_req,       1);
        check("stall_busy", ME_Stall,       1);
        check("wen_busy",   ME_WriteEnable, 0);
        check("dout_busy",  ME_Dout,        0);
        check("we",         dmem_we,        wr);
        check("addr",       dmem_addr,      addr & 32'hFFFF_FFFC);
        check("be",         dmem_be,        wr ? ref_be(opt, addr) : 4'd0);
        if (wr) check("wdata", dmem_wdata, ref_wdata(opt, data));
        check("buserr", ME_BusErr, exp_buserr);
        step();
      end
      dmem_ready = 1'($urandom);
      dmem_rdata = $urandom;
      @(negedge clock);
      check("req_done",   dmem_req,       0);
      check("stall_done", ME_Stall,       0);
      check("wen_done",   ME_WriteEnable, wen);
      check("dout_done",  ME_Dout,        load ? rword : 32'd0);
      check("buserr",     ME_BusErr,      exp_buserr);
      step();
    end else begin
      dmem_ready = 1'($urandom);
      dmem_rdata = $urandom;
      @(negedge clock);
      check("req_nop",   dmem_req,       0);
      check("stall_nop", ME_Stall,       0);
      check("wen_nop",   ME_WriteEnable, wen);
      check("dout_nop",  ME_Dout,        0);
      step();
    end
  endtask

  initial begin
    int unsigned max_wait;
    reset             = 1'b0;
    ME_MemRead        = 1'b1;
    ME_MemWrite       = 1'b0;
    ME_ALUResult      = 32'h100;
    ME_StoreData      = '0;
    ME_store_option   = 2'b10;
    ME_WriteEnable_in = 1'b1;
    dmem_ready        = 1'b0;
    dmem_rdata        = '0;
`ifdef DMEM_TIMEOUT_EN
    max_wait = 4;
`else
    max_wait = 6;
`endif

    @(negedge clock);
    check("rst_req",    dmem_req,       0);
    check("rst_stall",  ME_Stall,       0);
    check("rst_wen",    ME_WriteEnable, 0);
    check("rst_dout",   ME_Dout,        0);
    check("rst_buserr", ME_BusErr,      0);
    step();
    step();
    reset = 1'b1;

    run_op(1, 0, 32'h104, 32'h0, 2'b10, 1, 0, 32'h1122_3344);
    run_op(0, 1, 32'h203, 32'hAABB_CCDD, 2'b00, 0, 3, 32'h0);
    run_op(0, 1, 32'h202, 32'h0000_1234, 2'b01, 0, 1, 32'h0);
    run_op(0, 1, 32'h207, 32'h5566_7788, 2'b10, 0, 0, 32'h0);
    run_op(1, 0, 32'h300, 32'h0, 2'b10, 1, 0, 32'hCAFE_0001);
    run_op(1, 0, 32'h304, 32'h0, 2'b10, 1, 0, 32'hCAFE_0002);
    run_op(1, 1, 32'h401, 32'h0000_00EE, 2'b11, 1, 2, 32'h0);
    run_op(0, 0, 32'h0, 32'h0, 2'b00, 1, 0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      int unsigned kind = $urandom_range(0, 3);
      run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, $urandom, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, max_wait), $urandom);
    end

    // Reset while waiting: request and stall must drop in the same cycle.
    ME_MemRead = 1'b1; ME_MemWrite = 1'b0; ME_ALUResult = 32'h500;
    ME_WriteEnable_in = 1'b1; dmem_ready = 1'b0;
    step();
    @(negedge clock);
    check("wait_req", dmem_req, 1);
    #1;
    reset      = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h7777_7777;
    #1;
    check("midrst_req",   dmem_req,       0);
    check("midrst_stall", ME_Stall,       0);
    check("midrst_wen",   ME_WriteEnable, 0);
    step();
    reset = 1'b1; ME_MemRead = 1'b0; dmem_ready = 1'b0;
    exp_buserr = 1'b0;
    @(negedge clock);
    check("post_rst_dout",  ME_Dout,  0);
    check("post_rst_stall", ME_Stall, 0);
    step();
    run_op(1, 0, 32'h600, 32'h0, 2'b10, 1, 0, 32'h0BAD_F00D);

`ifdef DMEM_TIMEOUT_EN
    ME_MemRead = 1'b1; ME_MemWrite = 1'b0; ME_ALUResult = 32'h700;
    ME_WriteEnable_in = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("to_req", dmem_req, 1);
      step();
    end
    @(negedge clock);
    check("to_req_done", dmem_req,  0);
    check("to_dout",     ME_Dout,   32'hDEAD_BEEF);
    check("to_buserr",   ME_BusErr, 1);
    exp_buserr = 1'b1;
    step();
    run_op(1, 0, 32'h704, 32'h0, 2'b10, 1, 1, 32'h1357_9BDF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
